output_buf: RTL and testbench

OUTPUT_BUF -- requirements
Module: output_buf

---
 rtl/output_buf_pkg.sv | 25 ++
 rtl/output_buf.sv | 138 +++++++++++++
 tb/tb_output_buf.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/output_buf_pkg.sv
// ----------------------------------------------------------------------------
// output_buf_pkg
// Shared definitions for the result transmit path:
//   DATABUS_W  - width of one output beat on the pins
//   RESBUS_W   - width of one result word from the matrix multiplier
//   NUM_RES    - result words packed into one frame
//   FRAME_W    - total frame width in bits
//   BEAT_CNT   - beats needed to send one frame
//   state_t    - transmit FSM state encoding
// ----------------------------------------------------------------------------
package output_buf_pkg;

    localparam int DATABUS_W = 2;
    localparam int RESBUS_W  = 4;
    localparam int NUM_RES   = 4;
    localparam int FRAME_W   = NUM_RES * RESBUS_W;
    localparam int BEAT_CNT  = FRAME_W / DATABUS_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : output_buf_pkg

// File: rtl/output_buf.sv
// ----------------------------------------------------------------------------
// output_buf
// Transmit buffer between the matrix multiplier results and the output pins.
// A load pulse captures {res0,res1,res2,res3} as one frame, which is then
// streamed out DATA_W bits per beat, res0 first and MSB-first within a word.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   load       in   one-cycle request to capture res0..res3
//   res0..res3 in   RES_W-bit result words
//   ready_in   in   downstream can take a beat
//   data_out   out  current beat (0 when valid_out is low)
//   valid_out  out  data_out holds a valid beat
//   busy       out  state is not IDLE
//   done       out  one-cycle pulse after the last beat is accepted
//   overrun    out  sticky: a load arrived while not IDLE
//   state_dbg  out  current FSM state (state_t encoding)
//
// Handshake: a beat transfers on a rising edge where valid_out=1 and
// ready_in=1. While valid_out=1 and ready_in=0, data_out holds stable.
// valid_out never depends combinationally on ready_in.
//
// All outputs are registered: the next-state logic computes the values for
// the following cycle and they are captured together with the state.
// ----------------------------------------------------------------------------
module output_buf
    import output_buf_pkg::*;
#(
    parameter int DATA_W  = DATABUS_W,
    parameter int RES_W   = RESBUS_W,
    parameter int NUM_RES = output_buf_pkg::NUM_RES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [RES_W-1:0]  res0,
    input  logic [RES_W-1:0]  res1,
    input  logic [RES_W-1:0]  res2,
    input  logic [RES_W-1:0]  res3,
    input  logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [1:0]        state_dbg
);

    localparam int FRM_W = NUM_RES * RES_W;
    localparam int BEATS = FRM_W / DATA_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t             state, state_nxt;
    logic [FRM_W-1:0]   shreg, shreg_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               overrun_nxt;
    logic [DATA_W-1:0]  data_nxt;
    logic               valid_nxt;
    logic               busy_nxt;
    logic               done_nxt;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            overrun   <= 1'b0;
            data_out  <= '0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            cnt       <= cnt_nxt;
            overrun   <= overrun_nxt;
            data_out  <= data_nxt;
            valid_out <= valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        cnt_nxt     = cnt;
        overrun_nxt = overrun;

        case (state)
            ST_IDLE: begin
                if (load) begin
                    shreg_nxt   = FRM_W'({res0, res1, res2, res3});
                    cnt_nxt     = '0;
                    overrun_nxt = 1'b0;
                    state_nxt   = ST_SEND;
                end
            end
            ST_SEND: begin
                // valid_out is always high in SEND, so ready_in alone
                // decides whether the current beat is taken.
                if (ready_in) begin
                    shreg_nxt = shreg << DATA_W;
                    cnt_nxt   = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BEATS - 1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A load outside IDLE is dropped; only the sticky flag records it.
        if (load && (state != ST_IDLE)) begin
            overrun_nxt = 1'b1;
        end

        valid_nxt = (state_nxt == ST_SEND);
        data_nxt  = valid_nxt ? shreg_nxt[FRM_W-1 -: DATA_W] : '0;
        busy_nxt  = (state_nxt != ST_IDLE);
        done_nxt  = (state_nxt == ST_DONE);
    end

    assign state_dbg = state;

endmodule : output_buf

// File: tb/tb_output_buf.sv
// ----------------------------------------------------------------------------
// tb_output_buf
// Self-checking bench for output_buf: reset state, table-driven directed
// frames (plain and with back-pressure), hand-written overrun / mid-frame
// reset / back-to-back sequences, then randomized traffic against a
// queue-based reference model.
// ----------------------------------------------------------------------------
module tb_output_buf;

  localparam int DW = 2;
  localparam int RW = 4;
  localparam int FW = 16;
  localparam int NB = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [RW-1:0] res0 = '0, res1 = '0, res2 = '0, res3 = '0;
  logic          ready_in = 1'b0;
  logic [DW-1:0] data_out;
  logic          valid_out, busy, done, overrun;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  output_buf #(.DATA_W(DW), .RES_W(RW), .NUM_RES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .res0      (res0),
    .res1      (res1),
    .res2      (res2),
    .res3      (res3),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] exp_q[$];   // beats still to be delivered
  bit            m_done;     // done pulse expected this cycle
  bit            m_ovr;      // expected overrun flag

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // {valid, data, done, busy, overrun}
  function automatic logic [5:0] dut_out();
    return {valid_out, data_out, done, busy, overrun};
  endfunction

  function automatic logic [5:0] model_out();
    logic          v;
    logic [DW-1:0] d;
    v = (exp_q.size() != 0);
    d = v ? exp_q[0] : '0;
    return {v, d, m_done, v | m_done, m_ovr};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_done = 0;
    m_ovr  = 0;
  endtask

  // Frame as a list of beats: res0 first, MSB-first.
  task automatic push_frame(input logic [FW-1:0] f);
    for (int i = 0; i < NB; i++) exp_q.push_back(f[(FW-1-DW*i) -: DW]);
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input bit ld, input logic [FW-1:0] f, input bit rdy);
    bit idle;
    idle = (exp_q.size() == 0) && !m_done;
    if (m_done) m_done = 0;
    else if (exp_q.size() != 0 && rdy) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) m_done = 1;
    end
    if (ld) begin
      if (idle) begin
        push_frame(f);
        m_ovr = 0;
      end else begin
        m_ovr = 1;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Drive inputs for one cycle, step past the edge, compare to the model.
  task automatic cyc(input string name, input bit ld, input logic [FW-1:0] f, input bit rdy);
    load = ld;
    {res0, res1, res2, res3} = f;
    ready_in = rdy;
    @(posedge clk);
    #1;
    model_edge(ld, f, rdy);
    check(name, {26'd0, dut_out()}, {26'd0, model_out()});
    load = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         ld;
    bit         rdy;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit ld, input bit rdy, input bit v, input logic [1:0] d,
                              input bit dn, input bit b, input bit o);
    vec_t r;
    r.ld  = ld;
    r.rdy = rdy;
    r.exp = {v, d, dn, b, o};
    vecs.push_back(r);
  endfunction

  localparam logic [FW-1:0] FRAME_A = 16'hA53C;   // beats 2,2,1,1,0,3,3,0

  int busy_low;
  int vcount;
  logic [FW-1:0] rf;

  initial begin
    model_reset();

    // ---------- reset state ----------
    #12;
    check("reset_outputs", {26'd0, dut_out()}, 32'd0);
    check("reset_state", {30'd0, state_dbg}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_release", {26'd0, dut_out()}, 32'd0);

    // ---------- table: plain frame ----------
    add(1, 1, 1, 2'd2, 0, 1, 0);
    add(0, 1, 1, 2'd2, 0, 1, 0);
    add(0, 1, 1, 2'd1, 0, 1, 0);
    add(0, 1, 1, 2'd1, 0, 1, 0);
    add(0, 1, 1, 2'd0, 0, 1, 0);
    add(0, 1, 1, 2'd3, 0, 1, 0);
    add(0, 1, 1, 2'd3, 0, 1, 0);
    add(0, 1, 1, 2'd0, 0, 1, 0);
    add(0, 1, 0, 2'd0, 1, 1, 0);
    add(0, 1, 0, 2'd0, 0, 0, 0);
    // ---------- table: 3 stalled cycles on the third beat ----------
    add(1, 1, 1, 2'd2, 0, 1, 0);
    add(0, 1, 1, 2'd2, 0, 1, 0);
    add(0, 1, 1, 2'd1, 0, 1, 0);
    add(0, 0, 1, 2'd1, 0, 1, 0);
    add(0, 0, 1, 2'd1, 0, 1, 0);
    add(0, 0, 1, 2'd1, 0, 1, 0);
    add(0, 1, 1, 2'd1, 0, 1, 0);
    add(0, 1, 1, 2'd0, 0, 1, 0);
    add(0, 1, 1, 2'd3, 0, 1, 0);
    add(0, 1, 1, 2'd3, 0, 1, 0);
    add(0, 1, 1, 2'd0, 0, 1, 0);
    add(0, 1, 0, 2'd0, 1, 1, 0);
    add(0, 0, 0, 2'd0, 0, 0, 0);

    vcount = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      load = vecs[i].ld;
      {res0, res1, res2, res3} = FRAME_A;
      ready_in = vecs[i].rdy;
      @(posedge clk); #1;
      if (i >= 10 && valid_out) vcount++;
      check($sformatf("vec%0d", i), {26'd0, dut_out()}, {26'd0, vecs[i].exp});
    end
    load = 1'b0;
    check("stall_valid_cycles", vcount, 11);

    // ---------- overrun: load re-pulsed during SEND ----------
    cyc("ovr_load", 1, FRAME_A, 1);
    cyc("ovr_beat", 0, FRAME_A, 1);
    cyc("ovr_beat", 0, FRAME_A, 1);
    cyc("ovr_repulse", 1, 16'hF53C, 1);
    for (int i = 0; i < 7; i++) cyc("ovr_tail", 0, FRAME_A, 1);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);
    cyc("ovr_clear_load", 1, 16'h0F0F, 1);
    check("ovr_cleared", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 9; i++) cyc("ovr_frame2", 0, 16'h0, 1);

    // ---------- reset mid-frame ----------
    cyc("rst_load", 1, 16'h1234, 1);
    for (int i = 0; i < 4; i++) cyc("rst_beat", 0, 16'h0, 1);
    rst_n = 1'b0;
    #1;
    check("rst_valid_now", {31'd0, valid_out}, 32'd0);
    check("rst_busy_now", {31'd0, busy}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    check("rst_held", {26'd0, dut_out()}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc("rst_no_done", 0, 16'h0, 1);
    vcount = 0;
    cyc("replay_load", 1, FRAME_A, 1);
    if (valid_out) vcount++;
    for (int i = 0; i < 10; i++) begin
      cyc("replay", 0, 16'h0, 1);
      if (valid_out) vcount++;
    end
    check("replay_beats", vcount, 8);

    // ---------- back-to-back frames ----------
    busy_low = 0;
    cyc("b2b_load1", 1, 16'h5A5A, 1);
    for (int i = 0; i < 8; i++) begin
      cyc("b2b_f1", 0, 16'h0, 1);
      if (!busy) busy_low++;
    end
    cyc("b2b_idle", 0, 16'h0, 1);
    if (!busy) busy_low++;
    cyc("b2b_load2", 1, 16'hC3C3, 1);
    if (!busy) busy_low++;
    for (int i = 0; i < 8; i++) begin
      cyc("b2b_f2", 0, 16'h0, 1);
      if (!busy) busy_low++;
    end
    check("b2b_busy_gap", busy_low, 1);
    cyc("b2b_end", 0, 16'h0, 1);

    // ---------- randomized traffic ----------
    for (int i = 0; i < 800; i++) begin
      rf = 16'($urandom_range(0, 65535));
      cyc("rand", ($urandom_range(0, 5) == 0), rf, ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 40; i++) cyc("drain", 0, 16'h0, 1);
    check("drain_empty", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_output_buf
